// File: rtl/ram_loader_pkg.sv
// Shared constants and state encoding for the RAM program loader.
package ram_loader_pkg;

   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned RAM_DEPTH  = 2 ** ADDR_W_DEF;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StVerify
   } loader_state_e;

endpackage

// File: rtl/ram_loader.sv
// Streams bytes into the RAM at consecutive addresses, then optionally reads the whole RAM
// back and flags a checksum mismatch.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter bit          VERIFY = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic              ri,
   output logic              ro,
   output logic [DATA_W-1:0] data_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wr_sum_q, wr_sum_d;
   logic [DATA_W-1:0] rd_sum_q, rd_sum_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         wr_sum_q <= '0;
         rd_sum_q <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wr_sum_q <= wr_sum_d;
         rd_sum_q <= rd_sum_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wr_sum_d = wr_sum_q;
      rd_sum_d = rd_sum_q;
      done_d   = 1'b0;
      error_d  = error_q;
      in_ready = 1'b0;
      ri       = 1'b0;
      ro       = 1'b0;
      data_o   = '0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d   = '0;
               wr_sum_d = '0;
               rd_sum_d = '0;
               error_d  = 1'b0;
               state_d  = StLoad;
            end
         end

         StLoad: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ri       = 1'b1;
               data_o   = in_data;
               wr_sum_d = wr_sum_q + in_data;
               // Increment wraps to 0 after the last address, ready for readback.
               addr_d   = addr_q + 1'b1;
               if (addr_q == LastAddr) begin
                  if (VERIFY) begin
                     state_d = StVerify;
                  end else begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
            end
         end

         StVerify: begin
            // RAM read is combinational, so data_i belongs to this cycle's address.
            ro       = 1'b1;
            rd_sum_d = rd_sum_q + data_i;
            addr_d   = addr_q + 1'b1;
            if (addr_q == LastAddr) begin
               error_d = (rd_sum_d != wr_sum_q);
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   assign mem_address = addr_q;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign error       = error_q;

endmodule
